// File: rtl/bcd_display_controller.sv
// bcd_display_controller
//   Sequential binary-to-BCD converter for a bank of seven-segment displays.
//   A shift-add-3 (double-dabble) FSM converts one input bit per clock, then
//   latches the result into registered BCD and active-low segment outputs so
//   the display never shows intermediate values.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   bin_in    WIDTH-bit unsigned value to convert
//   start     conversion request (honoured only while idle)
//   blank_lz  1 = blank leading zero digits (digit 0 is never blanked)
//   busy      high while a conversion is in progress
//   done      one-cycle pulse when a new result becomes visible
//   bcd_out   latched BCD result, digit 0 in [3:0]
//   seg_out   active-low segments, digit n in [8n+7:8n], order {dp,g,f,e,d,c,b,a}
module bcd_display_controller #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4,
    parameter int AUTO   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  start,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [8*DIGITS-1:0]   seg_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    localparam int CNT_W = $clog2(WIDTH + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint unsigned MAX_IN = (64'd1 << WIDTH) - 64'd1;

    // The digit count must be able to represent the largest input value.
    if (pow10(DIGITS) <= MAX_IN) begin : g_digits_too_few
        $error("bcd_display_controller: DIGITS too small for WIDTH");
    end

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    logic [1:0]           state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 valid_q, valid_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     shreg_q, shreg_d;
    logic [WIDTH-1:0]     last_q, last_d;
    logic [4*DIGITS-1:0]  scratch_q, scratch_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic [8*DIGITS-1:0]  seg_q, seg_d;

    logic                 trigger;
    logic [4*DIGITS-1:0]  adjusted;
    logic [8*DIGITS-1:0]  seg_enc;
    logic                 higher_zero;

    assign trigger = start | ((AUTO != 0) & (~valid_q | (bin_in != last_q)));

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        adjusted = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
    end

    // Segment encoding of the finished scratch value; walk from the top digit
    // down so a digit is blanked only when it and everything above it is zero.
    always_comb begin
        seg_enc     = '1;
        higher_zero = 1'b1;
        for (int n = DIGITS - 1; n >= 0; n--) begin
            higher_zero = higher_zero & (scratch_q[4*n +: 4] == 4'd0);
            if (blank_lz && (n != 0) && higher_zero) seg_enc[8*n +: 8] = 8'hFF;
            else seg_enc[8*n +: 8] = seg7(scratch_q[4*n +: 4]);
        end
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        count_d   = count_q;
        shreg_d   = shreg_q;
        last_d    = last_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        seg_d     = seg_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                shreg_d   = bin_in;
                last_d    = bin_in;
                scratch_d = '0;
                count_d   = CNT_W'(WIDTH);
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                {scratch_d, shreg_d} = {adjusted, shreg_q} << 1;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) state_d = ST_LATCH;
            end
            default: begin // ST_LATCH
                bcd_d   = scratch_q;
                seg_d   = seg_enc;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            count_q   <= '0;
            shreg_q   <= '0;
            last_q    <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            seg_q     <= '1;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
            shreg_q   <= shreg_d;
            last_q    <= last_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            seg_q     <= seg_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign seg_out = seg_q;

endmodule
